mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
Multi-cycle control state machine for the MIPS CPU core. It sequences each instruction through fetch, decode, execute, memory and writeback. Each cycle it drives the ALU operand-source select (alusrc), the ALU operation, register-file, PC and memory enables. It sits beside the datapath, decodes the latched instruction's opcode/funct, and waits on ready handshakes from instruction and data memory.

Parameters:
IMEM_WAIT_MAX, 0, 0 = wait for imem_ready indefinitely; N>0 = raise bus_err after N wait cycles in FETCH.
DMEM_WAIT_MAX, 0, same rule for data memory in MEM_ACC.

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
opcode  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0] from instruction register
zero  in  1  ALU zero flag
imem_ready  in  1  instruction word valid this cycle
dmem_ready  in  1  data access complete this cycle
imem_req  out  1  instruction fetch request
dmem_req  out  1  data access request
dmem_we  out  1  1 = store, 0 = load (qualified by dmem_req)
ir_we  out  1  load instruction register
pc_we  out  1  update PC
pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target
alusrc  out  1  1 = register operand B, 0 = extended immediate
ext_sign  out  1  1 = sign-extend imm16, 0 = zero-extend
alu_op  out  4  ALU operation code
reg_we  out  1  register-file write enable
reg_dst  out  2  0 = rt, 1 = rd, 2 = $31
wb_sel  out  2  0 = ALU result, 1 = load data, 2 = PC+4
instr_done  out  1  one-cycle pulse when an instruction retires
illegal  out  1  one-cycle pulse on an unsupported opcode/funct
bus_err  out  1  one-cycle pulse on a memory wait timeout

Behaviour:
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_ACC, WB, BRANCH, JUMP.
- Reset: state=FETCH. All outputs 0 during any cycle with rst=1; alusrc=0, pc_src=0, alu_op=ADD. The wait counter clears.
- Reset mid-instruction aborts it: no partial reg_we, pc_we or dmem_req the following cycle.
- FETCH:
  - imem_req=1 while waiting.
  - When imem_ready=1: ir_we=1, pc_we=1, pc_src=0, then go to DECODE.
- DECODE: latch opcode/funct class, then dispatch:
  - R-type to EXEC_R.
  - addi/addiu/andi/ori/xori/slti/sltiu/lui to EXEC_I.
  - lw/sw to MEM_ADDR.
  - beq/bne to BRANCH.
  - j/jal to JUMP.
  - Anything else: illegal=1, then FETCH; no retire pulse.
- EXEC_R: alusrc=1; alu_op from funct (add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra). Then WB with reg_dst=1, wb_sel=0.
- EXEC_I: alusrc=0; alu_op from opcode. ext_sign=0 for andi/ori/xori/lui, 1 otherwise. Then WB with reg_dst=0, wb_sel=0.
- MEM_ADDR: alusrc=0, ext_sign=1, alu_op=ADD, then MEM_ACC.
- MEM_ACC:
  - dmem_req=1 and dmem_we=(sw), held stable until dmem_ready.
  - On ready: sw retires and goes to FETCH; lw goes to WB with reg_dst=0, wb_sel=1.
- WB: reg_we=1 for exactly one cycle, instr_done=1, then FETCH.
- BRANCH:
  - alusrc=1, alu_op=SUB.
  - pc_we=(zero XNOR is_beq) and pc_src=1 (zero is sampled in this cycle, Mealy).
  - instr_done=1, then FETCH.
- JUMP: pc_we=1, pc_src=2. For jal also reg_we=1, reg_dst=2, wb_sel=2. instr_done=1, then FETCH.
- Latency with zero-wait memory: R/I-type 4 cycles, lw 5, sw 4, branch/jump 3.
- Timeout: the wait counter counts from 0 in FETCH/MEM_ACC. When count reaches *_WAIT_MAX-1 with no ready: bus_err=1, drop the request, go to FETCH. PC is not updated on a timeout.
- If ready arrives in the same cycle as the timeout threshold, ready wins.
- At most one of reg_we / dmem_req+dmem_we asserts in any cycle.

Decomposition:
- Shared package mips_ctrl_pkg:
  - State enum.
  - ALU op codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLTU=7, SLL=8, SRL=9, SRA=10, LUI=11.
  - Opcode/funct constants.
  - pc_src, reg_dst and wb_sel encodings.
- One combinational sub-module, mc_alu_decode: (opcode, funct) -> alu_op, ext_sign, legal flag.

Test Plan:
- rst=1 for 2 cycles while imem_ready=1 -> all outputs 0; first imem_req=1 in the cycle after rst falls.
- add (opcode 0, funct 0x20), zero-wait memory -> cycle 3 has alusrc=1, alu_op=0; cycle 4 has reg_we=1, reg_dst=1, instr_done=1; total 4 cycles.
- lw (0x23) with dmem_ready delayed 3 cycles -> dmem_req held 4 cycles with dmem_we=0; then one WB cycle with wb_sel=1, reg_we=1; total 8 cycles.
- beq (0x04): zero=1 gives pc_we=1, pc_src=1; zero=0 gives pc_we=0. bne (0x05) gives the inverse.
- jal (0x03) -> JUMP cycle has pc_we=1, pc_src=2, reg_we=1, reg_dst=2, wb_sel=2.
- opcode 0x3F gives illegal pulse, no reg_we, next state FETCH. With DMEM_WAIT_MAX=4 and sw held with no ready: bus_err after 4 request cycles, no instr_done.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multi-cycle MIPS control FSM and its ALU decoder
package mips_ctrl_pkg;
  typedef logic [3:0] state_t;
  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_EXEC_R   = 4'd2;
  localparam state_t S_EXEC_I   = 4'd3;
  localparam state_t S_MEM_ADDR = 4'd4;
  localparam state_t S_MEM_ACC  = 4'd5;
  localparam state_t S_WB       = 4'd6;
  localparam state_t S_BRANCH   = 4'd7;
  localparam state_t S_JUMP     = 4'd8;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;
  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;
  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
endpackage

// File: rtl/mc_alu_decode.sv
// mc_alu_decode: maps opcode/funct to ALU operation, immediate extension and legality
// Ports: opcode, funct in; alu_op, ext_sign (1 = sign-extend), legal out. Purely combinational.
module mc_alu_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       ext_sign,
  output logic       legal
);
  always_comb begin
    alu_op = ALU_ADD;
    ext_sign = 1'b1;
    legal = 1'b1;
    case (opcode)
      OP_RTYPE:
        case (funct)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          FN_SRA:  alu_op = ALU_SRA;
          default: legal = 1'b0;
        endcase
      OP_SLTI:  alu_op = ALU_SLT;
      OP_SLTIU: alu_op = ALU_SLTU;
      OP_ANDI: begin alu_op = ALU_AND; ext_sign = 1'b0; end
      OP_ORI:  begin alu_op = ALU_OR;  ext_sign = 1'b0; end
      OP_XORI: begin alu_op = ALU_XOR; ext_sign = 1'b0; end
      OP_LUI:  begin alu_op = ALU_LUI; ext_sign = 1'b0; end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL: alu_op = ALU_ADD;
      default: legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control sequencer (fetch/decode/execute/memory/writeback)
// Ports: clk, rst (sync, active-high); opcode/funct from the IR; zero flag; imem_ready/dmem_ready
// handshakes. Drives memory requests, IR/PC/regfile enables, datapath selects and the
// instr_done / illegal / bus_err status pulses. All outputs are forced low while rst is high.
module mc_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int IMEM_WAIT_MAX = 0,
  parameter int DMEM_WAIT_MAX = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alusrc,
  output logic       ext_sign,
  output logic [3:0] alu_op,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_sel,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_err
);
  state_t state, nxt;
  logic [5:0] op_q, fn_q, dec_opc, dec_fn;
  logic [31:0] cnt;
  logic stay, in_dec, is_sw, is_lw, is_beq, is_jal, imem_tmo, dmem_tmo;
  logic [3:0] dec_alu_op;
  logic dec_ext, dec_legal;
  // In DECODE the IR is fresh, so decode it live; later states use the latched copy.
  assign in_dec = state == S_DECODE;
  assign dec_opc = in_dec ? opcode : op_q;
  assign dec_fn = in_dec ? funct : fn_q;
  assign is_sw = op_q == OP_SW;
  assign is_lw = op_q == OP_LW;
  assign is_beq = op_q == OP_BEQ;
  assign is_jal = op_q == OP_JAL;
  // A ready arriving on the threshold cycle suppresses the timeout.
  assign imem_tmo = IMEM_WAIT_MAX > 0 && !imem_ready && cnt == 32'(IMEM_WAIT_MAX - 1);
  assign dmem_tmo = DMEM_WAIT_MAX > 0 && !dmem_ready && cnt == 32'(DMEM_WAIT_MAX - 1);
  mc_alu_decode u_dec (
    .opcode  (dec_opc),
    .funct   (dec_fn),
    .alu_op  (dec_alu_op),
    .ext_sign(dec_ext),
    .legal   (dec_legal)
  );
  always_comb begin
    nxt = state;
    stay = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we = 1'b0;
    ir_we = 1'b0;
    pc_we = 1'b0;
    pc_src = PC_SEQ;
    alusrc = 1'b0;
    ext_sign = 1'b0;
    alu_op = ALU_ADD;
    reg_we = 1'b0;
    reg_dst = RD_RT;
    wb_sel = WB_ALU;
    instr_done = 1'b0;
    illegal = 1'b0;
    bus_err = 1'b0;
    if (!rst)
      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we = imem_ready;
          pc_we = imem_ready;
          bus_err = imem_tmo;
          stay = !imem_ready && !imem_tmo;
          nxt = imem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          illegal = !dec_legal;
          nxt = !dec_legal ? S_FETCH :
                opcode == OP_RTYPE ? S_EXEC_R :
                (opcode == OP_LW || opcode == OP_SW) ? S_MEM_ADDR :
                (opcode == OP_BEQ || opcode == OP_BNE) ? S_BRANCH :
                (opcode == OP_J || opcode == OP_JAL) ? S_JUMP : S_EXEC_I;
        end
        S_EXEC_R: begin
          alusrc = 1'b1;
          alu_op = dec_alu_op;
          nxt = S_WB;
        end
        S_EXEC_I: begin
          alu_op = dec_alu_op;
          ext_sign = dec_ext;
          nxt = S_WB;
        end
        S_MEM_ADDR: begin
          ext_sign = 1'b1;
          nxt = S_MEM_ACC;
        end
        S_MEM_ACC: begin
          dmem_req = 1'b1;
          dmem_we = is_sw;
          bus_err = dmem_tmo;
          instr_done = dmem_ready && is_sw;
          stay = !dmem_ready && !dmem_tmo;
          nxt = dmem_ready ? (is_sw ? S_FETCH : S_WB) : dmem_tmo ? S_FETCH : S_MEM_ACC;
        end
        S_WB: begin
          reg_we = 1'b1;
          instr_done = 1'b1;
          reg_dst = op_q == OP_RTYPE ? RD_RD : RD_RT;
          wb_sel = is_lw ? WB_MEM : WB_ALU;
          nxt = S_FETCH;
        end
        S_BRANCH: begin
          alusrc = 1'b1;
          alu_op = ALU_SUB;
          pc_src = PC_BR;
          pc_we = zero ~^ is_beq;
          instr_done = 1'b1;
          nxt = S_FETCH;
        end
        S_JUMP: begin
          pc_we = 1'b1;
          pc_src = PC_JMP;
          reg_we = is_jal;
          reg_dst = is_jal ? RD_RA : RD_RT;
          wb_sel = is_jal ? WB_PC4 : WB_ALU;
          instr_done = 1'b1;
          nxt = S_FETCH;
        end
        default: nxt = S_FETCH;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      cnt <= '0;
      op_q <= '0;
      fn_q <= '0;
    end else begin
      state <= nxt;
      cnt <= stay ? cnt + 32'd1 : '0;
      if (in_dec) begin
        op_q <= opcode;
        fn_q <= funct;
      end
    end
  end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: randomized scoreboard bench for mc_ctrl_fsm with a per-instruction reference model
module tb_mc_ctrl_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic imem_req, dmem_req, dmem_we, ir_we, pc_we, alusrc, ext_sign, reg_we;
  logic instr_done, illegal, bus_err;
  logic [1:0] pc_src, reg_dst, wb_sel;
  logic [3:0] alu_op;
  logic [20:0] all_out;
  assign all_out = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, alusrc, ext_sign, alu_op,
                    reg_we, reg_dst, wb_sel, instr_done, illegal, bus_err};
  mc_ctrl_fsm #(.IMEM_WAIT_MAX(0), .DMEM_WAIT_MAX(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .alusrc(alusrc), .ext_sign(ext_sign), .alu_op(alu_op),
    .reg_we(reg_we), .reg_dst(reg_dst), .wb_sel(wb_sel), .instr_done(instr_done),
    .illegal(illegal), .bus_err(bus_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    int kind;
    int lat;
    bit chk_ex;
    bit alusrc;
    int alu_op;
    bit chk_ext;
    bit ext;
    int n_dreq;
    int n_dwe;
    int n_regwe;
    int n_pcwe;
    int pc_src;
    int reg_dst;
    int wb_sel;
  } exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0;
  int r_fn [13] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2a, 'h2b, 'h00, 'h02, 'h03};
  int r_op [13] = '{0, 0, 1, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
  int i_opc [8] = '{'h08, 'h09, 'h0a, 'h0b, 'h0c, 'h0d, 'h0e, 'h0f};
  int i_op [8] = '{0, 0, 6, 7, 2, 3, 4, 11};
  int i_ext [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
  int pool [20] = '{0, 0, 0, 8, 9, 10, 11, 12, 13, 14, 15, 35, 43, 35, 43, 4, 5, 2, 3, 63};
  function automatic void chk(string name, int act, int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, want);
    end
  endfunction
  // Reference: kind 0 = retire, 1 = illegal, 2 = bus error; wi/wd = memory wait cycles.
  function automatic exp_t model(int op, int fn, int wi, int wd, bit z);
    exp_t e = '{default: 0};
    int f = wi + 1;
    int idx = -1;
    bit taken;
    e.n_pcwe = 1;
    if (op == 0) begin
      for (int i = 0; i < 13; i++) if (r_fn[i] == fn) idx = i;
      if (idx < 0) begin e.kind = 1; e.lat = f + 1; end
      else begin
        e.lat = f + 3; e.chk_ex = 1; e.alusrc = 1; e.alu_op = r_op[idx];
        e.n_regwe = 1; e.reg_dst = 1; e.wb_sel = 0;
      end
      return e;
    end
    for (int i = 0; i < 8; i++) if (i_opc[i] == op) idx = i;
    if (idx >= 0) begin
      e.lat = f + 3; e.chk_ex = 1; e.alusrc = 0; e.alu_op = i_op[idx];
      e.chk_ext = 1; e.ext = i_ext[idx] != 0; e.n_regwe = 1; e.reg_dst = 0; e.wb_sel = 0;
    end else if (op == 'h23 || op == 'h2b) begin
      e.chk_ex = 1; e.chk_ext = 1; e.ext = 1; e.alusrc = 0; e.alu_op = 0;
      if (wd < 4) begin
        e.n_dreq = wd + 1;
        if (op == 'h23) begin e.lat = f + wd + 4; e.n_regwe = 1; e.reg_dst = 0; e.wb_sel = 1; end
        else begin e.lat = f + wd + 3; e.n_dwe = wd + 1; end
      end else begin
        e.kind = 2; e.lat = f + 6; e.n_dreq = 4; e.n_dwe = op == 'h2b ? 4 : 0;
      end
    end else if (op == 4 || op == 5) begin
      taken = z == (op == 4);
      e.lat = f + 2; e.chk_ex = 1; e.alusrc = 1; e.alu_op = 1;
      e.n_pcwe = taken ? 2 : 1; e.pc_src = taken ? 1 : 0;
    end else if (op == 2 || op == 3) begin
      e.lat = f + 2; e.n_pcwe = 2; e.pc_src = 2;
      if (op == 3) begin e.n_regwe = 1; e.reg_dst = 2; e.wb_sel = 2; end
    end else begin
      e.kind = 1; e.lat = f + 1;
    end
    return e;
  endfunction
  initial begin
    int cyc, d, n_dreq, n_dwe, n_regwe, n_pcwe, pcs, rdst, wbs, ex_as, ex_op, ex_ext, kind;
    bit fresh;
    exp_t e;
    fresh = 1;
    forever begin
      @(negedge clk);
      #1;
      if (rst || fresh) begin
        cyc = 0; d = -1; n_dreq = 0; n_dwe = 0; n_regwe = 0; n_pcwe = 0;
        pcs = 0; rdst = 0; wbs = 0; ex_as = 0; ex_op = 0; ex_ext = 0; fresh = 0;
      end
      if (!rst) begin
        cyc++;
        if (d >= 0) d++;
        if (ir_we) d = 0;
        if (d == 2) begin ex_as = int'(alusrc); ex_op = int'(alu_op); ex_ext = int'(ext_sign); end
        if (dmem_req) n_dreq++;
        if (dmem_req && dmem_we) n_dwe++;
        if (reg_we) begin n_regwe++; rdst = int'(reg_dst); wbs = int'(wb_sel); end
        if (pc_we) begin n_pcwe++; pcs = int'(pc_src); end
        chk("regwe_dmem_exclusive", int'(reg_we && dmem_req), 0);
        if (instr_done || illegal || bus_err) begin
          chk("one_status_pulse", int'(instr_done) + int'(illegal) + int'(bus_err), 1);
          chk("sb_has_entry", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            kind = bus_err ? 2 : illegal ? 1 : 0;
            chk("kind", kind, e.kind);
            chk("latency", cyc, e.lat);
            chk("dmem_req_cycles", n_dreq, e.n_dreq);
            chk("dmem_we_cycles", n_dwe, e.n_dwe);
            chk("reg_we_cycles", n_regwe, e.n_regwe);
            chk("pc_we_cycles", n_pcwe, e.n_pcwe);
            chk("pc_src", pcs, e.pc_src);
            if (e.n_regwe > 0) begin
              chk("reg_dst", rdst, e.reg_dst);
              chk("wb_sel", wbs, e.wb_sel);
            end
            if (e.chk_ex) begin
              chk("alusrc", ex_as, int'(e.alusrc));
              chk("alu_op", ex_op, e.alu_op);
            end
            if (e.chk_ext) chk("ext_sign", ex_ext, int'(e.ext));
          end
          fresh = 1;
        end
      end
    end
  end
  task automatic run_instr(input int op, input int fn, input int wi, input int wd, input bit z,
                           input bit first);
    int j = 0, k = 0;
    bit ended = 0;
    exp_q.push_back(model(op, fn, wi, wd, z));
    for (int c = 0; c < 80 && !ended; c++) begin
      @(negedge clk);
      zero = z;
      imem_ready = imem_req && (j == wi);
      if (imem_req) j++;
      if (imem_ready) begin opcode = 6'(op); funct = 6'(fn); end
      dmem_ready = dmem_req && (k == wd);
      if (dmem_req) k++;
      #1;
      if (first && c == 0) chk("first_imem_req", int'(imem_req), 1);
      ended = instr_done || illegal || bus_err;
    end
    chk("retire_seen", int'(ended), 1);
    if (!ended) begin
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  endtask
  initial begin
    int op, fn;
    imem_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("reset_outputs", int'(all_out), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    imem_ready = 1'b0;
    run_instr('h00, 'h20, 0, 0, 0, 1);
    run_instr('h23, 0, 0, 3, 0, 0);
    run_instr('h04, 0, 0, 0, 1, 0);
    run_instr('h04, 0, 1, 0, 0, 0);
    run_instr('h05, 0, 0, 0, 1, 0);
    run_instr('h05, 0, 0, 0, 0, 0);
    run_instr('h03, 0, 0, 0, 0, 0);
    run_instr('h02, 0, 2, 0, 0, 0);
    run_instr('h3f, 0, 0, 0, 0, 0);
    run_instr('h00, 'h01, 0, 0, 0, 0);
    run_instr('h2b, 0, 0, 9, 0, 0);
    run_instr('h2b, 0, 0, 3, 0, 0);
    run_instr('h23, 0, 2, 4, 0, 0);
    run_instr('h0c, 0, 0, 0, 0, 0);
    run_instr('h0f, 0, 0, 0, 0, 0);
    run_instr('h00, 'h03, 0, 0, 0, 0);
    for (int n = 0; n < 200; n++) begin
      op = pool[$urandom_range(0, 19)];
      fn = $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 63)) : r_fn[$urandom_range(0, 12)];
      run_instr(op, fn, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                1'($urandom_range(0, 1)), 0);
    end
    @(negedge clk);
    imem_ready = 1'b1;
    opcode = 6'h23;
    #1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      imem_ready = 1'b0;
      #1;
      if (dmem_req) break;
    end
    chk("abort_reached_mem", int'(dmem_req), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_reset_outputs", int'(all_out), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_refetch", int'({imem_req, reg_we, pc_we, dmem_req}), 8);
    @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
